mat_operand_loader: RTL and testbench

- Upstream feeder for the matrix-multiply wrapper.
- Accepts a serial stream of W_IN-bit signed elements with a valid/ready handshake and a frame marker.
- Assembles two N×N operand matrices into one packed 2*N*N*W_IN bus, then pulses valid_out for one cycle. That pulse drives the wrapper's valid_in directly.
- Checks framing against the last-beat marker. Malformed frames are discarded and flagged.

---
 rtl/mat_operand_loader_pkg.sv | 13 +
 rtl/mat_operand_loader_if.sv | 16 +
 rtl/mat_operand_loader.sv | 85 ++++++++
 tb/tb_mat_operand_loader.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mat_operand_loader_pkg.sv
// Shared sizing for the operand loader and the matrix-multiply wrapper it feeds.
package mat_operand_loader_pkg;

  localparam int unsigned LOADER_W_IN = 8;
  localparam int unsigned LOADER_N    = 8;
  localparam int unsigned FRAME_BEATS = 2 * LOADER_N * LOADER_N;

  // Beats per frame: two N x N matrices, one element per beat.
  function automatic int unsigned frame_beats(input int unsigned n);
    return 2 * n * n;
  endfunction

endpackage

// File: rtl/mat_operand_loader_if.sv
// Valid/ready element stream with a last-beat frame marker.
interface mat_operand_loader_if
  import mat_operand_loader_pkg::*;
#(
  parameter int unsigned W_IN = LOADER_W_IN
);

  logic            s_valid;
  logic            s_ready;
  logic [W_IN-1:0] s_data;
  logic            s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/mat_operand_loader.sv
// Collects 2*N*N serial elements into a packed operand bus for the matmul wrapper.
// Malformed frames (early or missing s_last) are discarded and flagged on err_out.
module mat_operand_loader
  import mat_operand_loader_pkg::*;
#(
  parameter int unsigned W_IN = LOADER_W_IN,
  parameter int unsigned N    = LOADER_N
) (
  input  logic                     clk,
  input  logic                     resetn,
  mat_operand_loader_if.slave      s,
  output logic                     valid_out,
  output logic [2*N*N*W_IN-1:0]    data_out,
  output logic                     err_out
);

  localparam int unsigned BEATS = frame_beats(N);
  localparam int unsigned CW    = $clog2(BEATS);
  localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] DROP = 1'b1;

  logic [0:0]                  state;
  logic [CW-1:0]               cnt;
  logic                        ready;
  // The final beat bypasses staging and is merged straight into data_out.
  logic [(BEATS-1)*W_IN-1:0]   staging;
  logic                        accept;

  assign accept  = s.s_valid && ready;
  assign s.s_ready = ready;

  // Element staging; intentionally left unreset.
  always_ff @(posedge clk) begin
    if (accept && state == FILL && cnt != LAST_IDX) begin
      staging[cnt*W_IN +: W_IN] <= s.s_data;
    end
  end

  // Framing FSM, beat counter and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= FILL;
      cnt       <= '0;
      ready     <= 1'b0;
      valid_out <= 1'b0;
      err_out   <= 1'b0;
      data_out  <= '0;
    end else begin
      ready     <= 1'b1;
      valid_out <= 1'b0;
      err_out   <= 1'b0;
      if (accept) begin
        case (state)
          FILL: begin
            if (cnt == LAST_IDX) begin
              cnt <= '0;
              if (s.s_last) begin
                data_out  <= {s.s_data, staging};
                valid_out <= 1'b1;
              end else begin
                // Overlong frame: flag now, swallow beats up to its s_last.
                err_out <= 1'b1;
                state   <= DROP;
              end
            end else if (s.s_last) begin
              err_out <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DROP: begin
            if (s.s_last) begin
              state <= FILL;
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mat_operand_loader.sv
// Randomized and directed bench for mat_operand_loader with N=2, W_IN=8.
module tb_mat_operand_loader;

  localparam int unsigned W_IN  = 8;
  localparam int unsigned N     = 2;
  localparam int unsigned BEATS = 2 * N * N;
  localparam int unsigned DW    = BEATS * W_IN;

  logic          clk;
  logic          resetn;
  logic          valid_out;
  logic          err_out;
  logic [DW-1:0] data_out;

  mat_operand_loader_if #(.W_IN(W_IN)) bus ();

  mat_operand_loader #(.W_IN(W_IN), .N(N)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .s         (bus),
    .valid_out (valid_out),
    .data_out  (data_out),
    .err_out   (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame-level view of the stream.
  logic [7:0]    frame_q[$];
  bit            dropping;
  logic          exp_ready;
  logic          exp_valid;
  logic          exp_err;
  logic [DW-1:0] exp_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one model cycle given the inputs presented at the coming edge.
  task automatic model(input logic v, input logic [7:0] d, input logic l, input logic rn);
    logic          n_valid;
    logic          n_err;
    logic [DW-1:0] n_data;
    n_valid = 1'b0;
    n_err   = 1'b0;
    n_data  = exp_data;
    if (!rn) begin
      frame_q.delete();
      dropping = 1'b0;
      n_data   = '0;
    end else if (v && exp_ready) begin
      if (dropping) begin
        if (l) dropping = 1'b0;
      end else begin
        frame_q.push_back(d);
        if (l) begin
          if (frame_q.size() == BEATS) begin
            n_valid = 1'b1;
            for (int i = 0; i < BEATS; i++) n_data[i*8 +: 8] = frame_q[i];
          end else begin
            n_err = 1'b1;
          end
          frame_q.delete();
        end else if (frame_q.size() == BEATS) begin
          n_err    = 1'b1;
          dropping = 1'b1;
          frame_q.delete();
        end
      end
    end
    exp_ready = rn;
    exp_valid = n_valid;
    exp_err   = n_err;
    exp_data  = n_data;
  endtask

  // Check outputs mid-cycle, then present inputs for the next edge.
  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic rn);
    @(negedge clk);
    check("s_ready", {63'b0, bus.s_ready}, {63'b0, exp_ready});
    check("valid_out", {63'b0, valid_out}, {63'b0, exp_valid});
    check("err_out", {63'b0, err_out}, {63'b0, exp_err});
    check("data_out", data_out, exp_data);
    if (valid_out && err_out) check("pulse_excl", 64'd1, 64'd0);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.s_last  = l;
    resetn      = rn;
    model(v, d, l, rn);
    @(posedge clk);
  endtask

  task automatic send_seq(input logic [7:0] base, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b1, base + 8'(i), (i == n - 1), 1'b1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] signed_vals[BEATS];
    bit         do_last;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    resetn      = 1'b0;
    dropping    = 1'b0;
    repeat (2) @(posedge clk);
    exp_ready = 1'b0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_data  = '0;

    // Reset hold, then release: ready must lag release by one cycle.
    step(1'b0, 8'h00, 1'b0, 1'b0);
    idle(2);

    // Good frame.
    send_seq(8'h01, BEATS, 1'b0);
    #1 check("tp_good", data_out, 64'h0807060504030201);
    idle(2);

    // Gapped frame immediately followed by another frame.
    send_seq(8'h01, BEATS, 1'b1);
    send_seq(8'hF1, BEATS, 1'b0);
    #1 check("tp_b2b", data_out, 64'hF8F7F6F5F4F3F2F1);
    idle(2);

    // Early s_last, then a good frame.
    send_seq(8'h30, 5, 1'b0);
    idle(1);
    #1 check("tp_early_hold", data_out, 64'hF8F7F6F5F4F3F2F1);
    send_seq(8'h01, BEATS, 1'b0);
    idle(2);

    // Overlong frame of 11 beats, then a good frame.
    send_seq(8'h40, 11, 1'b0);
    idle(1);
    #1 check("tp_long_hold", data_out, 64'h0807060504030201);
    send_seq(8'hA1, BEATS, 1'b0);
    idle(2);

    // Reset after 4 beats of a frame.
    for (int i = 0; i < 4; i++) step(1'b1, 8'h50 + 8'(i), 1'b0, 1'b1);
    step(1'b1, 8'h54, 1'b0, 1'b0);
    #1 check("tp_rst_data", data_out, 64'h0);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    send_seq(8'h01, BEATS, 1'b0);
    #1 check("tp_rst_frame", data_out, 64'h0807060504030201);
    idle(2);

    // Signed values pass through unchanged.
    signed_vals = '{8'h80, 8'hFF, 8'h7F, 8'h00, 8'h01, 8'h81, 8'hFE, 8'h7E};
    for (int i = 0; i < BEATS; i++) step(1'b1, signed_vals[i], (i == BEATS - 1), 1'b1);
    #1 check("tp_signed", data_out, 64'h7EFE8101007FFF80);
    check("tp_signed_m2", {32'b0, data_out[63:32]}, 64'h7EFE8101);
    idle(2);

    // Random traffic with biased framing.
    for (int c = 0; c < 600; c++) begin
      if (dropping) do_last = ($urandom_range(0, 3) == 0);
      else if (frame_q.size() == BEATS - 1) do_last = ($urandom_range(0, 9) < 7);
      else do_last = ($urandom_range(0, 19) == 0);
      step(($urandom_range(0, 3) != 0), 8'($urandom), do_last,
           ($urandom_range(0, 149) != 0));
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
